// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit-address I2C target bridging bus transfers onto a byte-wide host register file.
// Latency: bus lines are seen 3 clk after the pads; reg_we rises 1 clk after the 8th data bit is sampled.
// Backpressure: none; the host must take reg_we every time and answer reg_rdata combinationally.
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       ptr_wr_q, ptr_wr_d;   // pointer already loaded since the first START of this transaction
  logic       mack_q, mack_d;       // master acknowledged the byte just read

  logic       start, stop, scl_rise, scl_fall;
  logic [7:0] byte_in;

  // SDA transitions only count as START/STOP while SCL is stably high
  assign start    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign scl_rise = scl_sync_q & ~scl_prev_q;
  assign scl_fall = ~scl_sync_q & scl_prev_q;
  assign byte_in  = {shreg_q[6:0], sda_sync_q};

  // Next-state logic: START beats STOP beats any SCL edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ptr_d    = we_q ? ptr_q + 8'd1 : ptr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    oe_d     = oe_q;
    busy_d   = busy_q;
    rw_d     = rw_q;
    ptr_wr_d = ptr_wr_q;
    mack_d   = mack_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
      if (!busy_q) ptr_wr_d = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      ptr_wr_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              case (state_q)
                ADDR: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state_d = ADDR_ACK;
                    rw_d    = byte_in[0];
                  end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                  end
                end
                REG: begin
                  ptr_d    = byte_in;
                  ptr_wr_d = 1'b1;
                  state_d  = REG_ACK;
                end
                default: begin
                  wdata_d = byte_in;
                  we_d    = 1'b1;
                  state_d = WDATA_ACK;
                end
              endcase
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          // first falling edge pulls SDA for the ACK slot, the second ends it
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q != ADDR_ACK) begin
                state_d = WDATA;
              end else if (rw_q) begin
                state_d = RDATA;
                shreg_d = reg_rdata;
                oe_d    = ~reg_rdata[7];
                ptr_d   = ptr_q + 8'd1;
              end else begin
                state_d = ptr_wr_q ? WDATA : REG;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              mack_d  = 1'b0;
              state_d = RDATA_ACK;
            end else begin
              oe_d = ~shreg_q[3'd7 - cnt_q[2:0]];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_sync_q) state_d = IDLE;
            else            mack_d  = 1'b1;
          end else if (scl_fall && mack_q) begin
            mack_d  = 1'b0;
            cnt_d   = '0;
            state_d = RDATA;
            shreg_d = reg_rdata;
            oe_d    = ~reg_rdata[7];
            ptr_d   = ptr_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, synchronizers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      ptr_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ptr_wr_q   <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ptr_wr_q   <= ptr_wr_d;
      mack_q     <= mack_d;
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-level I2C master plus host register file driving i2c_slave.
// Expected data comes from a byte-level memory model updated from the transfers the bench issues.
// SDA is a wired-AND of the master drive and the target pull-down.
module tb_i2c_slave;
  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in, sda_in, sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       scl_m, sda_m;

  logic [7:0]  host_mem  [256];
  logic [7:0]  model_mem [256];
  logic [15:0] wlog [4096];
  int          wcnt   = 0;
  int          oe_cnt = 0;
  logic        pl_vld = 1'b0;
  logic [7:0]  pl_addr, pl_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign scl_in    = scl_m;
  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = host_mem[reg_addr];

  i2c_slave #(.DEV_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // host register file: logs every write strobe and accepts preload pokes
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_cnt++;
    if (reg_we === 1'b1) begin
      wlog[wcnt % 4096] = {reg_addr, reg_wdata};
      wcnt++;
      host_mem[reg_addr] = reg_wdata;
    end
    if (pl_vld) host_mem[pl_addr] = pl_dat;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_dat = d; pl_vld = 1'b1; model_mem[a] = d;
    @(negedge clk); #1 pl_vld = 1'b0;
  endtask

  task automatic m_start();
    tick(4); sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b0; tick(8); scl_m = 1'b0;
  endtask

  task automatic m_stop();
    tick(4); sda_m = 1'b0; tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b1; tick(8);
  endtask

  task automatic m_wbit(input logic b);
    tick(4); sda_m = b; tick(4); scl_m = 1'b1; tick(8); scl_m = 1'b0;
  endtask

  task automatic m_rbit(output logic b);
    tick(4); sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(8); b = sda_in; scl_m = 1'b0;
  endtask

  // ack = 0 means the target acknowledged
  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(ack);
  endtask

  task automatic m_rbyte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin m_rbit(b); d[i] = b; end
    m_wbit(nack);
  endtask

  task automatic xfer_write(input logic [7:0] p, input logic [7:0] d[4], input int n, output int nacks);
    logic a;
    nacks = 0;
    m_start();
    m_wbyte(8'hA0, a); nacks += int'(a);
    m_wbyte(p, a);     nacks += int'(a);
    for (int i = 0; i < n; i++) begin m_wbyte(d[i], a); nacks += int'(a); end
    m_stop();
  endtask

  task automatic xfer_read(input logic [7:0] p, input int n, output logic [7:0] q[4], output int nacks);
    logic a;
    nacks = 0;
    m_start();
    m_wbyte(8'hA0, a); nacks += int'(a);
    m_wbyte(p, a);     nacks += int'(a);
    m_start();
    m_wbyte(8'hA1, a); nacks += int'(a);
    for (int i = 0; i < n; i++) m_rbyte(q[i], (i == n - 1));
    m_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3);
    checks++; if (sda_oe !== 1'b0)     begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
    checks++; if (reg_we !== 1'b0)     begin errors++; $display("FAIL rst_reg_we got %b want 0", reg_we); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (reg_addr !== 8'h00)  begin errors++; $display("FAIL rst_reg_addr got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL rst_reg_wdata got %h want 00", reg_wdata); end
    rst = 1'b0; tick(4);
  endtask

  task automatic test_write();
    logic a; int nacks = 0; int w0 = wcnt;
    m_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_start got %b want 1", busy); end
    m_wbyte(8'hA0, a); nacks += int'(a);
    m_wbyte(8'h10, a); nacks += int'(a);
    m_wbyte(8'hA5, a); nacks += int'(a);
    m_wbyte(8'h3C, a); nacks += int'(a);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got %b want 1", busy); end
    m_stop();
    model_mem[8'h10] = 8'hA5; model_mem[8'h11] = 8'h3C;
    checks++; if (nacks !== 0)        begin errors++; $display("FAIL wr_acks nacks %0d want 0", nacks); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL wr_busy_stop got %b want 0", busy); end
    checks++; if (wcnt - w0 !== 2)    begin errors++; $display("FAIL wr_count got %0d want 2", wcnt - w0); end
    checks++; if (wlog[w0] !== 16'h10A5)     begin errors++; $display("FAIL wr_first got %h want 10A5", wlog[w0]); end
    checks++; if (wlog[w0 + 1] !== 16'h113C) begin errors++; $display("FAIL wr_second got %h want 113C", wlog[w0 + 1]); end
    checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL wr_ptr got %h want 12", reg_addr); end
  endtask

  task automatic test_read();
    logic [7:0] q[4]; int nacks; int w0 = wcnt;
    poke(8'h20, 8'h5A); poke(8'h21, 8'hC3);
    xfer_read(8'h20, 2, q, nacks);
    checks++; if (nacks !== 0)        begin errors++; $display("FAIL rd_acks nacks %0d want 0", nacks); end
    checks++; if (q[0] !== model_mem[8'h20]) begin errors++; $display("FAIL rd_byte0 got %h want %h", q[0], model_mem[8'h20]); end
    checks++; if (q[1] !== model_mem[8'h21]) begin errors++; $display("FAIL rd_byte1 got %h want %h", q[1], model_mem[8'h21]); end
    checks++; if (reg_addr !== 8'h22) begin errors++; $display("FAIL rd_ptr got %h want 22", reg_addr); end
    checks++; if (wcnt !== w0)        begin errors++; $display("FAIL rd_no_write got %0d writes want 0", wcnt - w0); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rd_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_bad_addr();
    logic a; int c0 = oe_cnt; int w0 = wcnt;
    m_start();
    m_wbyte(8'hA2, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bad_addr_ack got %b want 1", a); end
    tick(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy got %b want 0", busy); end
    m_wbyte(8'h10, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bad_addr_ack2 got %b want 1", a); end
    m_wbyte(8'h77, a);
    m_stop();
    checks++; if (oe_cnt !== c0) begin errors++; $display("FAIL bad_addr_oe got %0d drive clks want 0", oe_cnt - c0); end
    checks++; if (wcnt !== w0)   begin errors++; $display("FAIL bad_addr_we got %0d writes want 0", wcnt - w0); end
  endtask

  task automatic test_wrap();
    logic [7:0] d[4]; int nacks; int w0 = wcnt;
    d[0] = 8'($urandom); d[1] = 8'($urandom); d[2] = 8'h00; d[3] = 8'h00;
    xfer_write(8'hFF, d, 2, nacks);
    model_mem[8'hFF] = d[0]; model_mem[8'h00] = d[1];
    checks++; if (nacks !== 0)     begin errors++; $display("FAIL wrap_acks nacks %0d want 0", nacks); end
    checks++; if (wcnt - w0 !== 2) begin errors++; $display("FAIL wrap_count got %0d want 2", wcnt - w0); end
    checks++; if (wlog[w0] !== {8'hFF, d[0]})     begin errors++; $display("FAIL wrap_first got %h want %h", wlog[w0], {8'hFF, d[0]}); end
    checks++; if (wlog[w0 + 1] !== {8'h00, d[1]}) begin errors++; $display("FAIL wrap_second got %h want %h", wlog[w0 + 1], {8'h00, d[1]}); end
  endtask

  task automatic test_stop_mid();
    logic a; int w0 = wcnt;
    m_start();
    m_wbyte(8'hA0, a); m_wbyte(8'h05, a);
    for (int i = 0; i < 4; i++) m_wbit(1'($urandom));
    m_stop();
    checks++; if (wcnt !== w0)     begin errors++; $display("FAIL stop_mid_we got %0d writes want 0", wcnt - w0); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL stop_mid_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL stop_mid_busy got %b want 0", busy); end
  endtask

  task automatic test_sr_abort();
    logic a; int nacks = 0; int w0 = wcnt;
    m_start();
    m_wbyte(8'hA0, a); nacks += int'(a);
    m_wbyte(8'h30, a); nacks += int'(a);
    for (int i = 0; i < 4; i++) m_wbit(1'b1);
    m_start();
    m_wbyte(8'hA0, a); nacks += int'(a);
    m_wbyte(8'h99, a); nacks += int'(a);
    m_stop();
    model_mem[8'h30] = 8'h99;
    checks++; if (nacks !== 0)     begin errors++; $display("FAIL sr_acks nacks %0d want 0", nacks); end
    checks++; if (wcnt - w0 !== 1) begin errors++; $display("FAIL sr_count got %0d want 1", wcnt - w0); end
    checks++; if (wlog[w0] !== 16'h3099) begin errors++; $display("FAIL sr_write got %h want 3099", wlog[w0]); end
  endtask

  task automatic test_rst_mid_read();
    logic a; logic [7:0] d[4]; int nacks; int w0;
    poke(8'h60, 8'h00);
    m_start();
    m_wbyte(8'hA0, a); m_wbyte(8'h60, a);
    m_start();
    m_wbyte(8'hA1, a);
    tick(4);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstrd_driving got %b want 1", sda_oe); end
    rst = 1'b1; tick(1);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstrd_release got %b want 0", sda_oe); end
    rst = 1'b0;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstrd_busy got %b want 0", busy); end
    tick(4); sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(8);
    d[0] = 8'h3E; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
    w0 = wcnt;
    xfer_write(8'h61, d, 1, nacks);
    model_mem[8'h61] = 8'h3E;
    checks++; if (nacks !== 0)     begin errors++; $display("FAIL rstrd_acks nacks %0d want 0", nacks); end
    checks++; if (wcnt - w0 !== 1 || wlog[w0] !== 16'h613E) begin errors++; $display("FAIL rstrd_write got %0d writes last %h want 1 613E", wcnt - w0, wlog[w0]); end
  endtask

  task automatic test_random();
    logic [7:0] d[4]; logic [7:0] q[4]; logic [7:0] p, rp, ea; int n, m, nacks, w0;
    for (int it = 0; it < 8; it++) begin
      p = 8'($urandom); n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      w0 = wcnt;
      xfer_write(p, d, n, nacks);
      checks++; if (nacks !== 0)     begin errors++; $display("FAIL rnd%0d_wr_acks nacks %0d want 0", it, nacks); end
      checks++; if (wcnt - w0 !== n) begin errors++; $display("FAIL rnd%0d_wr_count got %0d want %0d", it, wcnt - w0, n); end
      for (int i = 0; i < n; i++) begin
        ea = p + 8'(i);
        model_mem[ea] = d[i];
        checks++; if (wlog[(w0 + i) % 4096] !== {ea, d[i]}) begin errors++; $display("FAIL rnd%0d_wr%0d got %h want %h", it, i, wlog[(w0 + i) % 4096], {ea, d[i]}); end
      end
      rp = ($urandom_range(0, 1) == 0) ? p : 8'($urandom);
      m  = $urandom_range(1, 4);
      xfer_read(rp, m, q, nacks);
      checks++; if (nacks !== 0) begin errors++; $display("FAIL rnd%0d_rd_acks nacks %0d want 0", it, nacks); end
      for (int i = 0; i < m; i++) begin
        ea = rp + 8'(i);
        checks++; if (q[i] !== model_mem[ea]) begin errors++; $display("FAIL rnd%0d_rd%0d got %h want %h", it, i, q[i], model_mem[ea]); end
      end
      ea = rp + 8'(m);
      checks++; if (reg_addr !== ea) begin errors++; $display("FAIL rnd%0d_ptr got %h want %h", it, reg_addr, ea); end
    end
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    pl_addr = 8'h00; pl_dat = 8'h00;
    test_reset();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_stop_mid();
    test_sr_abort();
    test_rst_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit device address this target answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port scl_in  input  1  bus SCL level, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  bus SDA level, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  when 1, the pad pulls SDA low; when 0, SDA is released.
REQ-007 SHALL have port reg_addr  output  8  register pointer presented to the host register file.
REQ-008 SHALL have port reg_wdata  output  8  write data to the register file.
REQ-009 SHALL have port reg_we  output  1  one-clk write strobe.
REQ-010 SHALL have port reg_rdata  input  8  read data at reg_addr, combinational from the host.
REQ-011 SHALL have port busy  output  1  high from an accepted START until STOP or abort.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-FF synchronizers plus one edge register, for a 3-clk detection latency.
REQ-013 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both take effect in any state.
REQ-014 SHALL sample SDA only on synchronized SCL rising edges, and SHALL change sda_oe only on synchronized SCL falling edges.
REQ-015 SHALL implement the states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 IDLE: on START, go to ADDR with bit counter = 0 and busy = 1.
REQ-017 ADDR: shift in 8 bits MSB-first (7 address bits, then R/W).
- On a match with DEV_ADDR: go to ADDR_ACK.
- On a mismatch: go to IDLE and clear busy; sda_oe stays 0.
REQ-018 ADDR_ACK: drive sda_oe = 1 for one SCL period.
- W = 0: next state is REG, or WDATA if the pointer was already written in this transaction.
- W = 1: next state is RDATA.
REQ-019 REG: shift 8 bits into the pointer (reg_addr), then go to REG_ACK (ACK driven), then WDATA.
REQ-020 WDATA: after the 8th bit, pulse reg_we for exactly one clk with reg_wdata = received byte and reg_addr = current pointer.
- Then go to WDATA_ACK (ACK driven) and back to WDATA.
- The pointer increments by 1 on the clk after reg_we.
REQ-021 RDATA: on entry, load a shift register from reg_rdata, then increment the pointer.
- Drive sda_oe = ~bit, MSB first, on each SCL falling edge.
- After 8 bits, release SDA and go to RDATA_ACK.
REQ-022 RDATA_ACK: sample the master's bit.
- 0 (ACK): return to RDATA and load the next byte.
- 1 (NACK): release SDA and wait in IDLE-equivalent until STOP or START.
REQ-023 SHALL wrap the pointer 8'hFF -> 8'h00 with no error indication.
REQ-024 A repeated START in any non-IDLE state SHALL abort the current byte without issuing reg_we, release SDA on the next clk, and enter ADDR; the pointer is retained.
REQ-025 STOP in any state SHALL release SDA, clear busy, discard any partial byte, and go to IDLE.
REQ-026 A START and SCL edge detected in the same clk SHALL give START priority.

Reset
REQ-027 While rst = 1 at a clk edge: state = IDLE, sda_oe = 0, reg_we = 0, busy = 0, reg_addr = 8'h00, reg_wdata = 8'h00, bit counter = 0, and synchronizers = 1.
REQ-028 rst asserted mid-transaction SHALL release SDA on the following clk; the block resumes only on a fresh START after rst falls.

Verification
REQ-029 Write to 0x50 with pointer 0x10 and data 0xA5, 0x3C, then STOP -> ACK on all 4 bytes; reg_we pulses at 0x10/0xA5 and 0x11/0x3C; busy falls after STOP.
REQ-030 Write of pointer 0x20 only, repeated START, read of 2 bytes with host data 0x5A then 0xC3, master NACK on the 2nd byte -> SDA carries 0x5A, 0xC3; reg_addr ends at 0x22.
REQ-031 Address 0x51 -> no ACK (sda_oe stays 0), no reg_we, state IDLE until the next START.
REQ-032 Pointer 0xFF with two data bytes written -> writes land at 0xFF and 0x00.
REQ-033 STOP after 4 bits of a data byte -> no reg_we; sda_oe = 0; busy = 0.
REQ-034 rst pulsed during RDATA while driving 0 -> sda_oe = 0 the next clk; a later START at 0x50 completes normally.
